lsb_mem_port: RTL and testbench
===============================

Name: lsb_mem_port

Overview:
Responder end of the load/store-buffer data interface inside the memory controller. It accepts one level-held read or write request (address, value, length 1/2/4) and performs it byte-serially on the 8-bit RAM/IO port. It returns a one-cycle completion pulse, carrying assembled little-endian load data for reads. It also stalls IO writes on io_buffer_full and aborts speculative reads on pipeline clear.

Parameters:
ADDR_W, 32, width of data_addr and mem_a
DATA_W, 32, width of data_val and LSB_data_o
IO_HI, 17, upper bit of the 2-bit IO tag; address is IO when addr[IO_HI:IO_HI-1]==2'b11

Ports:
clk_in  input  1  clock; all logic on rising edge
rst_in  input  1  reset, synchronous, active-low
rdy_in  input  1  global ready; low freezes all state
clear  input  1  pipeline flush (mispredict)
data_r_en  input  1  load request, held high until completion seen
data_w_en  input  1  store request, held high until completion seen
data_addr  input  ADDR_W  byte address
data_val  input  DATA_W  store data, low bytes significant
data_len  input  32  byte count, only 1/2/4 legal
LSB_en_o  output  1  completion pulse, one cycle
LSB_data_o  output  DATA_W  load result, zero-extended; 0 for stores
mem_din  input  8  RAM/IO read byte, valid one cycle after its address
mem_dout  output  8  write byte
mem_a  output  ADDR_W  byte address to RAM/IO
mem_wr  output  1  1 = write mem_dout at mem_a this cycle
io_buffer_full  input  1  IO output buffer full
busy  output  1  high in any state other than IDLE; used by fetch arbiter

Behaviour:
- Priority: rst_in==0 > rdy_in==0 (hold all registers) > normal operation. All outputs are registered.
- Reset: state=IDLE; LSB_en_o=0, LSB_data_o=0, mem_a=0, mem_dout=0, mem_wr=0, busy=0; byte counters=0.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - data_w_en=1 accepts a write, except when the address is IO and io_buffer_full=1 (stays IDLE). Write has priority if both enables are high.
  - data_r_en=1 && !clear accepts a read.
  - Accept latches addr, len and val. It drives mem_a=addr on the same edge; for a write it also drives mem_dout=val[7:0] and mem_wr=1. Issue counter becomes 1.
- READ: the byte captured at edge k is mem_din → byte lane k-1, for the address issued at edge k-1.
  - While issued<len: mem_a<=addr+issued.
  - After the last issue: mem_a holds its value.
  - On the edge capturing byte len-1: LSB_en_o<=1, LSB_data_o<=assembled value with upper lanes 0, state→DONE.
  - Latency: LSB_en_o is high in the cycle after the len-th edge following acceptance (len=4: acceptance edge E0, done after E4).
  - clear in READ: state→IDLE, no LSB_en_o, data discarded.
- WRITE: each edge with issued<len drives mem_a<=addr+issued, mem_dout<=val byte[issued], mem_wr<=1, issued++.
  - IO stall: if the address is IO and io_buffer_full=1 at an issue edge, drive mem_wr<=0 and do not advance.
  - After the final byte: the next edge drives mem_wr<=0, LSB_en_o<=1, LSB_data_o<=0, state→DONE. Latency for an unstalled write is len edges.
  - clear is ignored in WRITE; only committed stores reach this block.
- DONE: LSB_en_o<=0, state→IDLE. No acceptance in DONE. This one-cycle cooldown covers the requester dropping its enable on the edge where it samples LSB_en_o.
- Address arithmetic wraps mod 2^ADDR_W.
- data_len values outside 1/2/4 are treated as 4.
- Requests arriving while not IDLE are ignored; the requester holds them.

Decomposition:
- def.v gets:
  - state encodings (IDLE/READ/WRITE/DONE)
  - IO tag constant 2'b11 and IO_HI
  - length codes 1/2/4
- No sub-module. Byte-lane assembly is a small indexed register write inside the block.

Test Plan:
- lw: request at 0x1000 with RAM bytes 11 22 33 44 → mem_a 0x1000..0x1003 on consecutive cycles, mem_wr=0; LSB_en_o pulses once after E4 with LSB_data_o=0x44332211.
- sh: data_val=0xAABBCCDD, addr 0x2002 → mem_wr=1 for two cycles: (0x2002,DD), (0x2003,CC). LSB_en_o after E2. busy high throughout, low after DONE.
- IO sb: addr 0x30000, io_buffer_full=1 for 3 cycles → no acceptance, mem_wr stays 0. After release, one write of the byte, then LSB_en_o.
- clear during lw: clear at E2 → state IDLE next cycle, LSB_en_o never asserts. A new lbu at 0x10 then returns mem byte 0x80 as 0x00000080.
- Held request: data_r_en kept high one extra cycle after LSB_en_o → exactly one completion, no relaunch, because of the DONE cooldown.
- Reset and rdy: rst_in=0 mid-write after byte 1 → next edge mem_wr=0, all outputs 0, IDLE. rdy_in=0 mid-read freezes mem_a and counters.

Source files
------------

// File: rtl/lsb_mem_port_pkg.sv
// Shared encodings for the load/store-buffer memory port: FSM states,
// IO address tag and access-length codes.
package lsb_mem_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] IO_TAG    = 2'b11;
  localparam int         IO_HI_DEF = 17;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Anything other than a byte or halfword access is handled as a word.
  function automatic logic [2:0] norm_len(input logic [31:0] len);
    case (len)
      32'd1:   return LEN_B;
      32'd2:   return LEN_H;
      default: return LEN_W;
    endcase
  endfunction

endpackage

// File: rtl/lsb_mem_port.sv
// Responder for load/store-buffer requests: runs 1/2/4-byte accesses
// byte-serially on the 8-bit RAM/IO port and returns a completion pulse.
//
// state  | meaning
// IDLE   | waiting for a request; store wins over load
// READ   | issuing addresses and collecting bytes into little-endian lanes
// WRITE  | issuing bytes; stalls while an IO store sees io_buffer_full
// DONE   | one-cycle cooldown after the completion pulse, no acceptance
module lsb_mem_port
  import lsb_mem_port_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IO_HI  = IO_HI_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              data_r_en,
  input  logic              data_w_en,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_val,
  input  logic [31:0]       data_len,
  output logic              LSB_en_o,
  output logic [DATA_W-1:0] LSB_data_o,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  output logic              busy
);

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] val_q;
  logic [2:0]        len_q;
  logic [2:0]        issued_q;
  logic              io_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  logic              en_q;
  logic [DATA_W-1:0] data_o_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;
  logic              busy_q;

  logic              req_io;
  logic              last_issued;
  logic [ADDR_W-1:0] next_addr;
  logic [7:0]        wr_byte;
  logic [1:0]        rd_lane;

  assign req_io      = (data_addr[IO_HI -: 2] == IO_TAG);
  assign last_issued = (issued_q == len_q);
  assign next_addr   = addr_q + ADDR_W'(issued_q);
  assign wr_byte     = val_q[{issued_q[1:0], 3'b000} +: 8];
  // Byte arriving now belongs to the address issued one edge earlier;
  // issued_q==4 wraps to lane 3 through the 2-bit subtraction.
  assign rd_lane     = issued_q[1:0] - 2'd1;

  always_comb begin
    rdata_d = rdata_q;
    rdata_d[{rd_lane, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      val_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      io_q       <= 1'b0;
      rdata_q    <= '0;
      en_q       <= 1'b0;
      data_o_q   <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else if (rdy_in) begin
      case (state_q)
        ST_IDLE: begin
          en_q     <= 1'b0;
          mem_wr_q <= 1'b0;
          if (data_w_en) begin
            if (!(req_io && io_buffer_full)) begin
              addr_q     <= data_addr;
              val_q      <= data_val;
              len_q      <= norm_len(data_len);
              io_q       <= req_io;
              issued_q   <= 3'd1;
              mem_a_q    <= data_addr;
              mem_dout_q <= data_val[7:0];
              mem_wr_q   <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= ST_WRITE;
            end
          end else if (data_r_en && !clear) begin
            addr_q   <= data_addr;
            val_q    <= data_val;
            len_q    <= norm_len(data_len);
            io_q     <= req_io;
            issued_q <= 3'd1;
            rdata_q  <= '0;
            mem_a_q  <= data_addr;
            busy_q   <= 1'b1;
            state_q  <= ST_READ;
          end
        end

        ST_READ: begin
          if (clear) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            rdata_q <= rdata_d;
            if (last_issued) begin
              en_q     <= 1'b1;
              data_o_q <= rdata_d;
              state_q  <= ST_DONE;
            end else begin
              mem_a_q  <= next_addr;
              issued_q <= issued_q + 3'd1;
            end
          end
        end

        ST_WRITE: begin
          if (last_issued) begin
            mem_wr_q <= 1'b0;
            en_q     <= 1'b1;
            data_o_q <= '0;
            state_q  <= ST_DONE;
          end else if (io_q && io_buffer_full) begin
            mem_wr_q <= 1'b0;
          end else begin
            mem_a_q    <= next_addr;
            mem_dout_q <= wr_byte;
            mem_wr_q   <= 1'b1;
            issued_q   <= issued_q + 3'd1;
          end
        end

        ST_DONE: begin
          en_q     <= 1'b0;
          busy_q   <= 1'b0;
          issued_q <= '0;
          state_q  <= ST_IDLE;
        end

        default: begin
          en_q     <= 1'b0;
          mem_wr_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign LSB_en_o   = en_q;
  assign LSB_data_o = data_o_q;
  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_lsb_mem_port.sv
// Self-checking bench for lsb_mem_port: directed scenarios plus random
// loads/stores compared against a byte-array reference memory.
module tb_lsb_mem_port;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear, data_r_en, data_w_en, io_buffer_full;
  logic [31:0] data_addr, data_val, data_len;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a, LSB_data_o;
  logic        LSB_en_o, mem_wr, busy;

  int errs   = 0;
  int checks = 0;

  lsb_mem_port #(.ADDR_W(32), .DATA_W(32), .IO_HI(17)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .data_r_en(data_r_en), .data_w_en(data_w_en), .data_addr(data_addr),
    .data_val(data_val), .data_len(data_len), .LSB_en_o(LSB_en_o),
    .LSB_data_o(LSB_data_o), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full),
    .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // Environment RAM (what the DUT talks to) and reference memory (what the
  // bench believes should be there); unwritten bytes follow a fixed hash.
  logic [7:0] env_ram [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
  endfunction
  function automatic logic [7:0] env_rd(input logic [31:0] a);
    if (env_ram.exists(a)) return env_ram[a];
    return dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction
  function automatic int len_of(input logic [31:0] ln);
    if (ln == 1) return 1;
    if (ln == 2) return 2;
    return 4;
  endfunction

  always @(negedge clk_in) mem_din = env_rd(mem_a);
  always @(posedge clk_in) if (mem_wr) env_ram[mem_a] = mem_dout;

  logic [31:0] ow_a[$];
  logic [7:0]  ow_d[$];
  logic [31:0] or_a[$];

  // Drives one request and records what the port does; checking is left to callers.
  task automatic run_txn(input bit w, input logic [31:0] a, input logic [31:0] v,
                         input logic [31:0] ln, input int st_from, input int st_n,
                         input bit hold, output int cyc, output logic [31:0] rdata,
                         output bit busy_bad, output bit after_bad);
    ow_a.delete(); ow_d.delete(); or_a.delete();
    data_w_en = w; data_r_en = !w; data_addr = a; data_val = v; data_len = ln;
    cyc = 0; rdata = '0; busy_bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (st_n > 0) io_buffer_full = (cyc >= st_from && cyc < st_from + st_n);
      @(posedge clk_in); @(negedge clk_in);
      cyc++;
      if (mem_wr) begin ow_a.push_back(mem_a); ow_d.push_back(mem_dout); end
      if (!w) or_a.push_back(mem_a);
      if (!busy) busy_bad = 1;
      if (LSB_en_o) begin rdata = LSB_data_o; break; end
    end
    io_buffer_full = 1'b0;
    if (!hold) begin data_w_en = 0; data_r_en = 0; end
    @(posedge clk_in); @(negedge clk_in);
    after_bad = LSB_en_o || busy || mem_wr;
    data_w_en = 0; data_r_en = 0;
  endtask

  task automatic test_reset();
    rst_in = 0; rdy_in = 1; clear = 0; data_r_en = 0; data_w_en = 0;
    io_buffer_full = 0; data_addr = 0; data_val = 0; data_len = 0;
    repeat (3) @(negedge clk_in);
    checks++;
    if ({LSB_en_o, mem_wr, busy} !== 3'b000) begin
      errs++; $display("FAIL reset_flags got=%b want=000", {LSB_en_o, mem_wr, busy});
    end
    checks++;
    if ({LSB_data_o, mem_a, mem_dout} !== 72'h0) begin
      errs++; $display("FAIL reset_data got=%h/%h/%h want=0", LSB_data_o, mem_a, mem_dout);
    end
    rst_in = 1;
    @(negedge clk_in);
  endtask

  task automatic test_lw();
    int cyc; logic [31:0] rd; bit bb, ab, ok;
    run_txn(0, 32'h1000, 0, 4, 0, 0, 0, cyc, rd, bb, ab);
    checks++;
    if (cyc !== 5) begin errs++; $display("FAIL lw_latency got=%0d want=5", cyc); end
    checks++;
    if (rd !== 32'h44332211) begin errs++; $display("FAIL lw_data got=%h want=44332211", rd); end
    ok = (or_a.size() == 5);
    for (int i = 0; i < or_a.size(); i++)
      if (or_a[i] !== 32'h1000 + ((i < 4) ? i : 3)) ok = 0;
    checks++;
    if (!ok) begin errs++; $display("FAIL lw_addr_seq got_n=%0d first=%h want 1000..1003", or_a.size(), (or_a.size() > 0) ? or_a[0] : 32'hx); end
    checks++;
    if (ow_a.size() != 0 || bb || ab) begin
      errs++; $display("FAIL lw_ctrl got writes=%0d busy_bad=%0d after_bad=%0d want 0/0/0", ow_a.size(), bb, ab);
    end
  endtask

  task automatic test_sh();
    int cyc; logic [31:0] rd; bit bb, ab;
    run_txn(1, 32'h2002, 32'hAABBCCDD, 2, 0, 0, 0, cyc, rd, bb, ab);
    ref_mem[32'h2002] = 8'hDD; ref_mem[32'h2003] = 8'hCC;
    checks++;
    if (cyc !== 3) begin errs++; $display("FAIL sh_latency got=%0d want=3", cyc); end
    checks++;
    if (ow_a.size() != 2 || ow_a[0] !== 32'h2002 || ow_d[0] !== 8'hDD ||
        ow_a[1] !== 32'h2003 || ow_d[1] !== 8'hCC) begin
      errs++; $display("FAIL sh_writes got_n=%0d want (2002,DD)(2003,CC)", ow_a.size());
    end
    checks++;
    if (rd !== 0 || bb || ab) begin
      errs++; $display("FAIL sh_ctrl got data=%h busy_bad=%0d after_bad=%0d want 0/0/0", rd, bb, ab);
    end
  endtask

  task automatic test_io_stall();
    int cyc; logic [31:0] rd; bit bb, ab, ok;
    data_w_en = 1; data_addr = 32'h30000; data_val = 32'h5A; data_len = 1;
    io_buffer_full = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); @(negedge clk_in);
      checks++;
      if (busy !== 0 || mem_wr !== 0) begin
        errs++; $display("FAIL io_block cyc%0d got busy=%b wr=%b want 0/0", i, busy, mem_wr);
      end
    end
    io_buffer_full = 0;
    run_txn(1, 32'h30000, 32'h5A, 1, 0, 0, 0, cyc, rd, bb, ab);
    ref_mem[32'h30000] = 8'h5A;
    checks++;
    if (cyc !== 2 || ow_a.size() != 1 || ow_a[0] !== 32'h30000 || ow_d[0] !== 8'h5A) begin
      errs++; $display("FAIL io_sb got cyc=%0d n=%0d want cyc=2 one write (30000,5A)", cyc, ow_a.size());
    end
    // Two stalled issue edges in the middle of an IO word store.
    run_txn(1, 32'h30010, 32'h01020304, 4, 1, 2, 0, cyc, rd, bb, ab);
    ok = (ow_a.size() == 4);
    for (int i = 0; i < 4 && i < ow_a.size(); i++) begin
      if (ow_a[i] !== 32'h30010 + i || ow_d[i] !== 8'(4 - i)) ok = 0;
      ref_mem[32'h30010 + i] = 8'(4 - i);
    end
    checks++;
    if (cyc !== 7 || !ok || ab) begin
      errs++; $display("FAIL io_sw_stall got cyc=%0d n=%0d after_bad=%0d want cyc=7 n=4", cyc, ow_a.size(), ab);
    end
  endtask

  task automatic test_clear();
    int cyc, pulses; logic [31:0] rd; bit bb, ab, bz;
    data_r_en = 1; data_addr = 32'h1000; data_len = 4;
    @(posedge clk_in); @(negedge clk_in);
    @(posedge clk_in); @(negedge clk_in);
    clear = 1;
    @(posedge clk_in); @(negedge clk_in);
    clear = 0; data_r_en = 0;
    pulses = LSB_en_o; bz = busy;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in); @(negedge clk_in);
      pulses += LSB_en_o; bz |= busy;
    end
    checks++;
    if (pulses != 0 || bz) begin
      errs++; $display("FAIL clear_abort got pulses=%0d busy=%b want 0/0", pulses, bz);
    end
    clear = 1; data_r_en = 1;
    @(posedge clk_in); @(negedge clk_in);
    @(posedge clk_in); @(negedge clk_in);
    checks++;
    if (busy !== 0) begin errs++; $display("FAIL clear_idle_block got busy=%b want 0", busy); end
    clear = 0; data_r_en = 0;
    run_txn(0, 32'h10, 0, 1, 0, 0, 0, cyc, rd, bb, ab);
    checks++;
    if (cyc !== 2 || rd !== 32'h80) begin
      errs++; $display("FAIL lbu_after_clear got cyc=%0d data=%h want 2/00000080", cyc, rd);
    end
  endtask

  task automatic test_held();
    int cyc, pulses; logic [31:0] rd; bit bb, ab, bz;
    run_txn(0, 32'h1000, 0, 2, 0, 0, 1, cyc, rd, bb, ab);
    pulses = 0; bz = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in); @(negedge clk_in);
      pulses += LSB_en_o; bz |= busy;
    end
    checks++;
    if (cyc !== 3 || rd !== 32'h2211) begin
      errs++; $display("FAIL held_data got cyc=%0d data=%h want 3/00002211", cyc, rd);
    end
    checks++;
    if (ab || pulses != 0 || bz) begin
      errs++; $display("FAIL held_relaunch got after_bad=%0d pulses=%0d busy=%b want 0", ab, pulses, bz);
    end
  endtask

  task automatic test_rdy();
    int n; logic [31:0] rd;
    data_r_en = 1; data_addr = 32'h1000; data_len = 4;
    @(posedge clk_in); @(negedge clk_in);
    @(posedge clk_in); @(negedge clk_in);
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_in); @(negedge clk_in);
      checks++;
      if (mem_a !== 32'h1001 || LSB_en_o !== 0 || busy !== 1) begin
        errs++; $display("FAIL rdy_freeze cyc%0d got a=%h en=%b busy=%b want 1001/0/1", i, mem_a, LSB_en_o, busy);
      end
    end
    rdy_in = 1;
    n = 0; rd = 'x;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_in); @(negedge clk_in);
      n++;
      if (LSB_en_o) begin rd = LSB_data_o; break; end
    end
    data_r_en = 0;
    @(posedge clk_in); @(negedge clk_in);
    checks++;
    if (n !== 3 || rd !== 32'h44332211) begin
      errs++; $display("FAIL rdy_resume got edges=%0d data=%h want 3/44332211", n, rd);
    end
  endtask

  task automatic test_reset_mid_write();
    data_w_en = 1; data_addr = 32'h2000; data_val = 32'h11223344; data_len = 4;
    @(posedge clk_in); @(negedge clk_in);
    @(posedge clk_in); @(negedge clk_in);
    rst_in = 0;
    @(posedge clk_in); @(negedge clk_in);
    ref_mem[32'h2000] = 8'h44; ref_mem[32'h2001] = 8'h33;
    checks++;
    if ({LSB_en_o, mem_wr, busy} !== 3'b000 || mem_a !== 0 || mem_dout !== 0 || LSB_data_o !== 0) begin
      errs++; $display("FAIL reset_mid_write got en=%b wr=%b busy=%b a=%h d=%h want all 0",
                       LSB_en_o, mem_wr, busy, mem_a, mem_dout);
    end
    data_w_en = 0; rst_in = 1;
    @(negedge clk_in);
  endtask

  task automatic test_random(input logic [31:0] base, input int n_txn, input string tag);
    int cyc, l, bad; logic [31:0] rd, exp, a, v, ln; bit bb, ab, w, ok;
    logic [31:0] lens [6];
    lens = '{32'd1, 32'd2, 32'd4, 32'd0, 32'd3, 32'd7};
    bad = 0;
    for (int t = 0; t < n_txn; t++) begin
      w  = 1'($urandom_range(0, 1));
      a  = base + $urandom_range(0, 63);
      v  = $urandom;
      ln = lens[$urandom_range(0, 5)];
      l  = len_of(ln);
      run_txn(w, a, v, ln, 0, 0, 0, cyc, rd, bb, ab);
      ok = (cyc == l + 1) && !bb && !ab;
      if (w) begin
        if (ow_a.size() != l || rd !== 0) ok = 0;
        for (int i = 0; i < l; i++) begin
          if (i < ow_a.size() && (ow_a[i] !== a + i || ow_d[i] !== v[8*i +: 8])) ok = 0;
          ref_mem[a + i] = v[8*i +: 8];
        end
      end else begin
        exp = 0;
        for (int i = 0; i < l; i++) exp[8*i +: 8] = ref_rd(a + i);
        if (rd !== exp || ow_a.size() != 0) ok = 0;
      end
      checks++;
      if (!ok) begin
        bad++;
        errs++;
        $display("FAIL %s txn%0d w=%0d a=%h len=%0d got cyc=%0d data=%h nwr=%0d want cyc=%0d data=%h",
                 tag, t, w, a, ln, cyc, rd, ow_a.size(), l + 1, w ? 32'h0 : exp);
      end
    end
  endtask

  initial begin
    env_ram[32'h1000] = 8'h11; env_ram[32'h1001] = 8'h22;
    env_ram[32'h1002] = 8'h33; env_ram[32'h1003] = 8'h44;
    env_ram[32'h10]   = 8'h80;
    ref_mem[32'h1000] = 8'h11; ref_mem[32'h1001] = 8'h22;
    ref_mem[32'h1002] = 8'h33; ref_mem[32'h1003] = 8'h44;
    ref_mem[32'h10]   = 8'h80;

    test_reset();
    test_lw();
    test_sh();
    test_io_stall();
    test_clear();
    test_held();
    test_rdy();
    test_reset_mid_write();
    test_random(32'h0004_0000, 40, "rand");
    test_random(32'hFFFF_FFE0, 12, "wrap");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
